// File: rtl/button_gesture.sv
// Gesture classifier: turns debounced press/release pulses into short, long,
// double and auto-repeat event strobes.
module button_gesture #(
    parameter int LONG_CYCLES   = 25000000,
    parameter int DBL_CYCLES    = 15000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic moment_of_press,
    input  logic moment_of_depress,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_tick,
    output logic gesture_active
);

    // state     | meaning
    // IDLE      | no gesture in progress
    // HELD1     | first press held, timing towards long press
    // WAIT2     | released, timing the double-press window
    // HELD2     | second press held, untimed
    // LONG_HELD | long press in progress, emitting repeat ticks
    typedef enum logic [2:0] {
        IDLE,
        HELD1,
        WAIT2,
        HELD2,
        LONG_HELD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_q, dbl_d;
    logic             rep_q, rep_d;
    logic             active_q;
    logic             press_v;

    // A simultaneous press and release is treated as a release only.
    assign press_v = moment_of_press & ~moment_of_depress;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (press_v) state_d = HELD1;
            end
            HELD1: begin
                if (moment_of_depress) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LONG_CYCLES - 1)) begin
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end
            end
            WAIT2: begin
                if (press_v) begin
                    state_d = HELD2;
                    cnt_d   = '0;
                    dbl_d   = 1'b1;
                end else if (cnt_q == CNT_W'(DBL_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end
            end
            HELD2: begin
                cnt_d = '0;
                if (moment_of_depress) state_d = IDLE;
            end
            LONG_HELD: begin
                if (moment_of_depress) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
                    cnt_d = '0;
                    rep_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            dbl_q    <= 1'b0;
            rep_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            dbl_q    <= dbl_d;
            rep_q    <= rep_d;
            active_q <= (state_d != IDLE);
        end
    end

    assign short_press    = short_q;
    assign long_press     = long_q;
    assign double_press   = dbl_q;
    assign repeat_tick    = rep_q;
    assign gesture_active = active_q;

endmodule

// File: tb/tb_button_gesture.sv
// Bench for button_gesture: expected strobes are queued with their edge
// number when stimulus is driven and matched as the DUT emits them.
module tb_button_gesture;

    localparam int LONG = 8;
    localparam int DBL  = 5;
    localparam int REP  = 3;

    localparam logic [3:0] K_SHORT = 4'b1000;
    localparam logic [3:0] K_LONG  = 4'b0100;
    localparam logic [3:0] K_DBL   = 4'b0010;
    localparam logic [3:0] K_REP   = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic moment_of_press = 1'b0;
    logic moment_of_depress = 1'b0;
    logic short_press, long_press, double_press, repeat_tick, gesture_active;

    button_gesture #(
        .LONG_CYCLES  (LONG),
        .DBL_CYCLES   (DBL),
        .REPEAT_CYCLES(REP),
        .CNT_W        (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .moment_of_press  (moment_of_press),
        .moment_of_depress(moment_of_depress),
        .short_press      (short_press),
        .long_press       (long_press),
        .double_press     (double_press),
        .repeat_tick      (repeat_tick),
        .gesture_active   (gesture_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [3:0] k;
    } ev_t;

    ev_t q[$];
    int  edge_cnt = 0;
    int  base     = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_cnt);
        end
    endtask

    // Strobes driven by edge e are stable at the following falling edge.
    always @(negedge clk) begin
        logic [3:0] s;
        ev_t        ev;
        s = {short_press, long_press, double_press, repeat_tick};
        while (q.size() > 0 && q[0].e < edge_cnt) begin
            ev = q.pop_front();
            chk("missed_event", edge_cnt, ev.e);
        end
        if (s != 4'b0000) begin
            chk("onehot", $countones(s), 1);
            if (q.size() == 0) begin
                chk("unexpected_strobe", int'(s), 0);
            end else begin
                ev = q.pop_front();
                chk("event_edge", edge_cnt, ev.e);
                chk("event_kind", int'(s), int'(ev.k));
            end
        end
    end

    task automatic expect_ev(input int rel_edge, input logic [3:0] k);
        ev_t ev;
        ev.e = base + rel_edge;
        ev.k = k;
        q.push_back(ev);
    endtask

    // Positions just after edge base+n-1, so the next rising edge is edge n.
    task automatic go_to(input int n);
        while (edge_cnt < base + n - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int n, input bit is_press);
        go_to(n);
        if (is_press) moment_of_press = 1'b1;
        else          moment_of_depress = 1'b1;
        @(posedge clk);
        #1;
        moment_of_press   = 1'b0;
        moment_of_depress = 1'b0;
    endtask

    task automatic finish_test(input string name);
        go_to(45);
        chk({name, "_pending"}, q.size(), 0);
        chk({name, "_idle"}, int'(gesture_active), 0);
        base = edge_cnt;
    endtask

    initial begin
        #2;
        chk("rst_short", int'(short_press), 0);
        chk("rst_long", int'(long_press), 0);
        chk("rst_active", int'(gesture_active), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = edge_cnt;

        // Short press
        go_to(10);
        chk("short_pre_active", int'(gesture_active), 0);
        pulse(10, 1'b1);
        chk("short_active_on", int'(gesture_active), 1);
        pulse(13, 1'b0);
        expect_ev(18, K_SHORT);
        go_to(18);
        chk("short_active_hold", int'(gesture_active), 1);
        go_to(19);
        chk("short_active_off", int'(gesture_active), 0);
        finish_test("short");

        // Long press with repeats; release on a repeat boundary gives no tick
        pulse(10, 1'b1);
        expect_ev(18, K_LONG);
        expect_ev(21, K_REP);
        expect_ev(24, K_REP);
        expect_ev(27, K_REP);
        pulse(30, 1'b0);
        chk("long_idle_after_release", int'(gesture_active), 0);
        finish_test("long");

        // Double press
        pulse(10, 1'b1);
        pulse(12, 1'b0);
        expect_ev(15, K_DBL);
        pulse(15, 1'b1);
        pulse(17, 1'b0);
        chk("dbl_idle_after_release", int'(gesture_active), 0);
        finish_test("double");

        // Release on the long-press limit edge wins
        pulse(10, 1'b1);
        pulse(18, 1'b0);
        expect_ev(23, K_SHORT);
        finish_test("long_bound");

        // Second press on the last window edge still counts as a double
        pulse(10, 1'b1);
        pulse(12, 1'b0);
        expect_ev(17, K_DBL);
        pulse(17, 1'b1);
        pulse(20, 1'b0);
        finish_test("dbl_bound");

        // Simultaneous press and release while idle does nothing
        go_to(10);
        moment_of_press   = 1'b1;
        moment_of_depress = 1'b1;
        @(posedge clk);
        #1;
        moment_of_press   = 1'b0;
        moment_of_depress = 1'b0;
        chk("both_idle", int'(gesture_active), 0);
        finish_test("both");

        // Reset mid-gesture discards it
        pulse(10, 1'b1);
        chk("rst_mid_active_before", int'(gesture_active), 1);
        go_to(14);
        rst = 1'b1;
        #1;
        chk("rst_mid_active", int'(gesture_active), 0);
        chk("rst_mid_strobes",
            int'({short_press, long_press, double_press, repeat_tick}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_held_idle", int'(gesture_active), 0);
        pulse(20, 1'b1);
        pulse(22, 1'b0);
        expect_ev(27, K_SHORT);
        finish_test("reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
